// File: rtl/acc_seq_pkg.sv
// Shared definitions for the acc_seq_8bit sequencer: command encodings and FSM state type.
package acc_seq_pkg;

   localparam logic [1:0] CMD_CLEAR = 2'b00;
   localparam logic [1:0] CMD_LOAD  = 2'b01;
   localparam logic [1:0] CMD_ADD   = 2'b10;
   localparam logic [1:0] CMD_SUB   = 2'b11;

   typedef enum logic {
      IDLE = 1'b0,
      EXEC = 1'b1
   } state_t;

endpackage

// File: rtl/acc_seq_8bit_sat.sv
// Clamps an overflowed add/sub result to the signed limit matching the accumulator's sign.
// Compiled only when ACC_SAT_EN is defined; the default build has no saturation.
`ifdef ACC_SAT_EN
module sat_8bit (
   input  logic [7:0] r,
   input  logic       of,
   input  logic       x_sign,
   output logic [7:0] value
);

   always_comb begin
      value = r;
      if (of) begin
         value = x_sign ? 8'h80 : 8'h7F;
      end
   end

endmodule
`endif

// File: rtl/acc_seq_8bit.sv
// Two-cycle accumulator sequencer driving an external 8-bit add/sub stage.
// Define ACC_SAT_EN to saturate acc on signed overflow instead of wrapping.
//
// state | meaning
// IDLE  | ready; accept a command and register operands for the add/sub stage
// EXEC  | add/sub stage result valid; write acc, pulse done, count the command
module acc_seq_8bit #(
   parameter int CNT_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic              cmd_ci,
   input  logic signed [7:0] cmd_data,
   output logic              add_op,
   output logic              add_ci,
   output logic [7:0]        add_x,
   output logic [7:0]        add_y,
   input  logic [7:0]        add_r,
   input  logic              add_of,
   output logic signed [7:0] acc,
   output logic              zero,
   output logic              neg,
   output logic              of_sticky,
   output logic              done,
   output logic [CNT_W-1:0]  op_cnt
);

   import acc_seq_pkg::*;

   state_t     state;
   logic [1:0] op_q;
   logic [7:0] alu_val;

`ifdef ACC_SAT_EN
   sat_8bit u_sat (
      .r      (add_r),
      .of     (add_of),
      .x_sign (add_x[7]),
      .value  (alu_val)
   );
`else
   assign alu_val = add_r;
`endif

   assign cmd_ready = (state == IDLE) && !rst;
   assign zero      = (acc == 8'sd0);
   assign neg       = acc[7];

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         op_q      <= CMD_CLEAR;
         acc       <= '0;
         of_sticky <= 1'b0;
         done      <= 1'b0;
         op_cnt    <= '0;
         add_x     <= '0;
         add_y     <= '0;
         add_op    <= 1'b0;
         add_ci    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  add_x  <= acc;
                  add_y  <= cmd_data;
                  add_op <= cmd_op[0];
                  add_ci <= cmd_ci;
                  op_q   <= cmd_op;
                  state  <= EXEC;
               end
            end
            EXEC: begin
               // add_r/add_of are only meaningful here, one cycle after add_* were registered
               case (op_q)
                  CMD_CLEAR: begin
                     acc       <= '0;
                     of_sticky <= 1'b0;
                  end
                  CMD_LOAD: acc <= add_y;
                  default: begin
                     acc <= alu_val;
                     if (add_of) begin
                        of_sticky <= 1'b1;
                     end
                  end
               endcase
               done   <= 1'b1;
               op_cnt <= op_cnt + CNT_W'(1);
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_acc_seq_8bit.sv
// Scoreboard bench for acc_seq_8bit with a behavioural model of the external add/sub stage.
// Expectations follow ACC_SAT_EN when the bench is compiled with it defined.
module tb_acc_seq_8bit;
   import acc_seq_pkg::*;

   typedef struct packed {
      logic [7:0] acc;
      logic       of;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       cmd_valid, cmd_ready, cmd_ci;
   logic [1:0] cmd_op;
   logic [7:0] cmd_data;
   logic       add_op, add_ci, add_of;
   logic [7:0] add_x, add_y, add_r;
   logic [7:0] acc;
   logic       zero, neg, of_sticky, done;
   logic [7:0] op_cnt;

   logic       c2_valid, c2_ready, c2_ci;
   logic [1:0] c2_op;
   logic [7:0] c2_data;
   logic       a2_op, a2_ci, a2_of;
   logic [7:0] a2_x, a2_y, a2_r;
   logic [7:0] acc2;
   logic       zero2, neg2, of2, done2;
   logic [1:0] cnt2;

   int   errors = 0;
   int   checks = 0;
   exp_t sb_q[$];
   logic [7:0] model_acc;
   logic       model_of;
   int   exp_cnt;

   always #5 clk = ~clk;

   // external add/sub stage: x+y+ci or x-y-ci, signed overflow flag
   function automatic logic [8:0] addsub(input logic [7:0] x, input logic [7:0] y,
                                         input logic op, input logic ci);
      int sx, sy, full;
      logic [7:0] r;
      sx = $signed(x);
      sy = $signed(y);
      full = op ? (sx - sy - int'(ci)) : (sx + sy + int'(ci));
      r = full[7:0];
      return {(full > 127) || (full < -128), r};
   endfunction

   assign {add_of, add_r} = addsub(add_x, add_y, add_op, add_ci);
   assign {a2_of, a2_r}   = addsub(a2_x, a2_y, a2_op, a2_ci);

   acc_seq_8bit u_dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_ci(cmd_ci), .cmd_data(cmd_data),
      .add_op(add_op), .add_ci(add_ci), .add_x(add_x), .add_y(add_y),
      .add_r(add_r), .add_of(add_of), .acc(acc), .zero(zero), .neg(neg),
      .of_sticky(of_sticky), .done(done), .op_cnt(op_cnt)
   );

   acc_seq_8bit #(.CNT_W(2)) u_dut2 (
      .clk(clk), .rst(rst), .cmd_valid(c2_valid), .cmd_ready(c2_ready),
      .cmd_op(c2_op), .cmd_ci(c2_ci), .cmd_data(c2_data),
      .add_op(a2_op), .add_ci(a2_ci), .add_x(a2_x), .add_y(a2_y),
      .add_r(a2_r), .add_of(a2_of), .acc(acc2), .zero(zero2), .neg(neg2),
      .of_sticky(of2), .done(done2), .op_cnt(cnt2)
   );

   function automatic void push_expect(input logic [1:0] op, input logic [7:0] d, input logic ci);
      int sx, sy, full;
      logic of;
      logic [7:0] nxt;
      exp_t e;
      case (op)
         CMD_CLEAR: begin model_acc = 8'h00; model_of = 1'b0; end
         CMD_LOAD:  model_acc = d;
         default: begin
            sx = $signed(model_acc);
            sy = $signed(d);
            full = (op == CMD_SUB) ? (sx - sy - int'(ci)) : (sx + sy + int'(ci));
            of = (full > 127) || (full < -128);
            nxt = full[7:0];
`ifdef ACC_SAT_EN
            if (of) nxt = model_acc[7] ? 8'h80 : 8'h7F;
`endif
            model_acc = nxt;
            model_of = model_of | of;
         end
      endcase
      exp_cnt++;
      e.acc = model_acc;
      e.of  = model_of;
      sb_q.push_back(e);
   endfunction

   // Called at a negedge; returns at the negedge where done is seen (lat=-1 if never)
   task automatic run_cmd(input logic [1:0] op, input logic [7:0] d, input logic ci,
                          output int lat);
      int n;
      lat = -1;
      cmd_op = op; cmd_data = d; cmd_ci = ci; cmd_valid = 1'b1;
      n = 0;
      while (cmd_ready !== 1'b1 && n < 8) begin
         @(negedge clk);
         n++;
      end
      if (cmd_ready !== 1'b1) begin
         cmd_valid = 1'b0;
         return;
      end
      @(posedge clk);
      push_expect(op, d, ci);
      @(negedge clk);
      cmd_valid = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         if (done === 1'b1) begin
            lat = k;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; cmd_valid = 1'b0; cmd_op = CMD_CLEAR; cmd_data = 8'h00; cmd_ci = 1'b0;
      c2_valid = 1'b0; c2_op = CMD_CLEAR; c2_data = 8'h00; c2_ci = 1'b0;
      model_acc = 8'h00; model_of = 1'b0; exp_cnt = 0;
      repeat (3) @(negedge clk);
      checks++;
      if ({acc, of_sticky, done, op_cnt} !== 18'h0) begin
         errors++;
         $display("FAIL reset_state: acc=%h of=%b done=%b cnt=%h want all 0", acc, of_sticky, done, op_cnt);
      end
      checks++;
      if ({add_x, add_y, add_op, add_ci} !== 18'h0) begin
         errors++;
         $display("FAIL reset_add: x=%h y=%h op=%b ci=%b want all 0", add_x, add_y, add_op, add_ci);
      end
      checks++;
      if (cmd_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_ready: got %b want 0", cmd_ready);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL ready_after_reset: got %b want 1", cmd_ready);
      end
   endtask

   task automatic test_add;
      int lat;
      exp_t e;
      run_cmd(CMD_LOAD, 8'h05, 1'b0, lat);
      checks++;
      if (lat != 2) begin errors++; $display("FAIL load_latency: got %0d want 2", lat); end
      e = (sb_q.size() != 0) ? sb_q.pop_front() : '0;
      checks++;
      if (acc !== e.acc) begin errors++; $display("FAIL load_acc: got %h want %h", acc, e.acc); end
      run_cmd(CMD_ADD, 8'h03, 1'b0, lat);
      checks++;
      if (lat != 2) begin errors++; $display("FAIL add_latency: got %0d want 2", lat); end
      e = (sb_q.size() != 0) ? sb_q.pop_front() : '0;
      checks++;
      if ({acc, zero, neg, of_sticky} !== {e.acc, e.acc == 8'h00, e.acc[7], e.of}) begin
         errors++;
         $display("FAIL add_result: acc=%h z=%b n=%b of=%b want acc=%h of=%b", acc, zero, neg, of_sticky, e.acc, e.of);
      end
      checks++;
      if (op_cnt !== exp_cnt[7:0]) begin errors++; $display("FAIL add_opcnt: got %0d want %0d", op_cnt, exp_cnt); end
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL done_one_cycle: got %b want 0", done); end
   endtask

   task automatic test_sub;
      int lat;
      exp_t e;
      run_cmd(CMD_SUB, 8'h0A, 1'b1, lat);
      checks++;
      if (add_op !== 1'b1 || add_ci !== 1'b1 || add_y !== 8'h0A) begin
         errors++;
         $display("FAIL sub_operands: op=%b ci=%b y=%h want 1 1 0a", add_op, add_ci, add_y);
      end
      e = (sb_q.size() != 0) ? sb_q.pop_front() : '0;
      checks++;
      if (lat != 2 || {acc, neg, of_sticky} !== {e.acc, e.acc[7], e.of}) begin
         errors++;
         $display("FAIL sub_result: lat=%0d acc=%h n=%b of=%b want acc=%h of=%b", lat, acc, neg, of_sticky, e.acc, e.of);
      end
   endtask

   task automatic test_overflow;
      int lat;
      exp_t e;
      logic [1:0] ops [6] = '{CMD_LOAD, CMD_ADD, CMD_LOAD, CMD_CLEAR, CMD_LOAD, CMD_SUB};
      logic [7:0] dat [6] = '{8'h7F, 8'h01, 8'h00, 8'h00, 8'h80, 8'h01};
      for (int i = 0; i < 6; i++) begin
         run_cmd(ops[i], dat[i], 1'b0, lat);
         e = (sb_q.size() != 0) ? sb_q.pop_front() : '0;
         checks++;
         if (lat != 2 || {acc, zero, of_sticky} !== {e.acc, e.acc == 8'h00, e.of}) begin
            errors++;
            $display("FAIL overflow_step%0d: lat=%0d acc=%h z=%b of=%b want acc=%h of=%b",
                     i, lat, acc, zero, of_sticky, e.acc, e.of);
         end
      end
   endtask

   task automatic test_back_to_back;
      int lat, accepts;
      exp_t e;
      run_cmd(CMD_CLEAR, 8'h00, 1'b0, lat);
      void'(sb_q.pop_front());
      @(negedge clk);
      accepts = 0;
      cmd_op = CMD_ADD; cmd_data = 8'h01; cmd_ci = 1'b0; cmd_valid = 1'b1;
      for (int i = 0; i <= 6; i++) begin
         if (done === 1'b1) begin
            e = (sb_q.size() != 0) ? sb_q.pop_front() : '0;
            checks++;
            if (acc !== e.acc) begin errors++; $display("FAIL b2b_acc: cyc %0d got %h want %h", i, acc, e.acc); end
         end
         if (i == 6) break;
         checks++;
         if (cmd_ready !== (i % 2 == 0)) begin
            errors++;
            $display("FAIL b2b_ready: cyc %0d got %b want %b", i, cmd_ready, (i % 2 == 0));
         end
         if (cmd_ready === 1'b1) begin
            accepts++;
            push_expect(CMD_ADD, 8'h01, 1'b0);
         end
         @(posedge clk);
         @(negedge clk);
         if (i == 5) cmd_valid = 1'b0;
      end
      checks++;
      if (accepts != 3 || acc !== 8'h03 || sb_q.size() != 0) begin
         errors++;
         $display("FAIL b2b_total: accepts=%0d acc=%h pending=%0d want 3 03 0", accepts, acc, sb_q.size());
      end
   endtask

   task automatic test_reset_exec;
      cmd_op = CMD_ADD; cmd_data = 8'h10; cmd_ci = 1'b0; cmd_valid = 1'b1;
      checks++;
      if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rexec_ready: got %b want 1", cmd_ready); end
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (acc !== 8'h00 || done !== 1'b0 || op_cnt !== 8'h00) begin
         errors++;
         $display("FAIL rexec_state: acc=%h done=%b cnt=%0d want 00 0 0", acc, done, op_cnt);
      end
      rst = 1'b0;
      model_acc = 8'h00; model_of = 1'b0; exp_cnt = 0;
      sb_q.delete();
      repeat (2) begin
         @(negedge clk);
         checks++;
         if (done !== 1'b0 || acc !== 8'h00 || op_cnt !== 8'h00) begin
            errors++;
            $display("FAIL rexec_nodone: done=%b acc=%h cnt=%0d want 0 00 0", done, acc, op_cnt);
         end
      end
   endtask

   task automatic test_cnt_wrap;
      logic [1:0] want;
      for (int k = 0; k < 4; k++) begin
         c2_op = CMD_LOAD; c2_data = 8'(k); c2_ci = 1'b0; c2_valid = 1'b1;
         want = 2'(k + 1);
         @(posedge clk);
         @(negedge clk);
         c2_valid = 1'b0;
         @(posedge clk);
         @(negedge clk);
         checks++;
         if (done2 !== 1'b1 || cnt2 !== want) begin
            errors++;
            $display("FAIL cnt_wrap%0d: done=%b cnt=%0d want 1 %0d", k, done2, cnt2, want);
         end
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub();
      test_overflow();
      test_back_to_back();
      test_reset_exec();
      test_cnt_wrap();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: timeout reached, errors=%0d of %0d checks", errors, checks);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/acc_seq_8bit.md
ACC_SEQ_8BIT -- requirements
Module: acc_seq_8bit

Interface
REQ-001 The block SHALL have parameter CNT_W, default 8, giving the width of the completed-operation counter.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; every register updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port cmd_valid, input, 1 bit: a command is offered.
REQ-005 The block SHALL have port cmd_ready, output, 1 bit: the block accepts a command this cycle.
REQ-006 The block SHALL have port cmd_op, input, 2 bits: 00 CLEAR, 01 LOAD, 10 ADD, 11 SUB.
REQ-007 The block SHALL have port cmd_ci, input, 1 bit: carry/borrow-in for ADD/SUB.
REQ-008 The block SHALL have port cmd_data, input, 8 bits signed: the operand.
REQ-009 The block SHALL have port add_op, output, 1 bit: registered op to the external 8-bit add/sub stage (1 means subtract).
REQ-010 The block SHALL have port add_ci, output, 1 bit: registered carry-in to that stage.
REQ-011 The block SHALL have ports add_x and add_y, outputs, 8 bits each: registered operands to that stage (x = accumulator, y = operand).
REQ-012 The block SHALL have port add_r, input, 8 bits: the combinational result from that stage.
REQ-013 The block SHALL have port add_of, input, 1 bit: the signed-overflow flag from that stage.
REQ-014 The block SHALL have port acc, output, 8 bits signed: the accumulator.
REQ-015 The block SHALL have ports zero and neg, outputs, 1 bit each: zero is acc==0 and neg is acc[7], both combinational from acc.
REQ-016 The block SHALL have port of_sticky, output, 1 bit: the sticky overflow flag.
REQ-017 The block SHALL have port done, output, 1 bit: a one-cycle completion pulse.
REQ-018 The block SHALL have port op_cnt, output, CNT_W bits: the count of completed commands, wrapping at the maximum value.

Function
REQ-019 The FSM SHALL have two states: IDLE and EXEC.
REQ-020 cmd_ready SHALL equal (state==IDLE) and not rst.
REQ-021 A command SHALL be accepted on any edge where cmd_valid and cmd_ready are both 1.
REQ-022 On acceptance, the block SHALL register add_x=acc, add_y=cmd_data, add_op=cmd_op[0], add_ci=cmd_ci, latch cmd_op, and go IDLE->EXEC.
REQ-023 In EXEC, the next edge SHALL update acc, pulse done=1 for exactly the following cycle, increment op_cnt, and go EXEC->IDLE.
REQ-024 The EXEC-edge acc update SHALL be 0 for CLEAR, the latched operand for LOAD, and add_r for ADD/SUB.
REQ-025 Result semantics SHALL be acc+y+ci for ADD and acc-y-ci for SUB, with 8-bit two's-complement wrap.
REQ-026 of_sticky SHALL be set when ADD/SUB completes with add_of=1, SHALL be cleared only by CLEAR or reset, and SHALL be left unchanged by LOAD.
REQ-027 Latency SHALL be 2 cycles from acceptance to acc valid, with a maximum throughput of one command per 2 cycles.
REQ-028 cmd_valid asserted while in EXEC SHALL be ignored, and the command SHALL remain pending until the next IDLE cycle.
REQ-029 The add_* outputs SHALL hold their values except at an acceptance edge.
REQ-030 The block SHALL ignore add_r and add_of outside EXEC.

Reset
REQ-031 While rst=1 at an edge, the block SHALL set state=IDLE; acc, of_sticky, done, op_cnt, add_x, add_y, add_op, add_ci all 0.
REQ-032 A reset during EXEC SHALL discard the in-flight command, with no done pulse and no op_cnt increment.
REQ-033 The first command SHALL be acceptable on the first edge after rst deasserts.

Configuration
REQ-034 With macro ACC_SAT_EN defined, an ADD/SUB that completes with add_of=1 SHALL write acc=0x7F when add_x[7]=0 and acc=0x80 when add_x[7]=1, and SHALL still set of_sticky.
REQ-035 Without ACC_SAT_EN, acc SHALL take add_r unmodified (wrapping).

Structure
REQ-036 Package acc_seq_pkg SHALL hold the cmd_op encoding constants (CMD_CLEAR, CMD_LOAD, CMD_ADD, CMD_SUB) and the FSM state typedef.
REQ-037 Saturation SHALL be a sub-module sat_8bit (inputs r, of, x_sign; output 8-bit value), instantiated only under ACC_SAT_EN.
REQ-038 The add/sub stage SHALL be external to this block and SHALL NOT be instantiated inside it.

Verification
REQ-039 The bench SHALL check: LOAD 0x05; ADD 0x03 ci=0 -> acc=0x08, zero=0, neg=0, of_sticky=0, done pulses 2 cycles after each acceptance.
REQ-040 The bench SHALL check: acc=0x08; SUB 0x0A ci=1 -> acc=0xFD, neg=1, of_sticky=0.
REQ-041 The bench SHALL check: LOAD 0x7F; ADD 0x01 -> acc=0x80 and of_sticky=1 (wrap); with ACC_SAT_EN acc=0x7F; then LOAD 0x00 -> of_sticky=1; then CLEAR -> of_sticky=0, zero=1.
REQ-042 The bench SHALL check: LOAD 0x80; SUB 0x01 -> acc=0x7F wrap, of_sticky=1; with ACC_SAT_EN acc=0x80.
REQ-043 The bench SHALL check: cmd_valid held high for 6 cycles with ADD 0x01 from acc=0 -> exactly 3 acceptances, acc=0x03, cmd_ready alternates 1/0.
REQ-044 The bench SHALL check: rst asserted in EXEC of ADD 0x10 -> acc=0, no done, op_cnt=0; and with CNT_W=2, 4 completed commands -> op_cnt=0.
